// File: rtl/arq_frame_tx.sv
// Stop-and-wait ARQ framer: wraps a byte as {start, seq, data, crc8} and shifts it
// out MSB first, then waits for ACK and retransmits on timeout up to MAX_RETRIES.
module arq_frame_tx #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_RETRIES    = 7
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       i_arq_en,
  input  logic       i_corrupt_en,
  output logic       o_otn_rx_data,
  input  logic       i_otn_tx_ack,
  output logic [7:0] o_crc_val,
  output logic [3:0] o_retry_cnt,
  output logic       o_tx_done,
  output logic       o_drop
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [17:0]   frame_q, frame_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    retry_q, retry_d;
  logic          seq_q, seq_d;
  logic          arq_q, arq_d;
  logic          corrupt_q, corrupt_d;
  logic          line_q, line_d;
  logic [7:0]    crc_q, crc_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          drop_q, drop_d;

  // CRC-8, poly 0x07, init 0, MSB first, no reflection or final XOR.
  function automatic logic [7:0] crc8(input logic [7:0] d);
    logic [7:0] c;
    c = d;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    tmo_d     = tmo_q;
    retry_d   = retry_q;
    seq_d     = seq_q;
    arq_d     = arq_q;
    corrupt_d = corrupt_q;
    crc_d     = crc_q;
    line_d    = 1'b0;
    done_d    = 1'b0;
    drop_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_valid && ready_q) begin
          frame_d   = {1'b1, seq_q, i_data, crc8(i_data)};
          crc_d     = crc8(i_data);
          arq_d     = i_arq_en;
          corrupt_d = i_corrupt_en;
          retry_d   = 4'd0;
          line_d    = 1'b1;
          bit_cnt_d = 5'd1;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (bit_cnt_q < 5'd18) begin
          // Bit index 9 is data[0]; only the first attempt of a corrupting frame flips it.
          line_d    = frame_q[5'd17 - bit_cnt_q] ^
                      (corrupt_q && (retry_q == 4'd0) && (bit_cnt_q == 5'd9));
          bit_cnt_d = bit_cnt_q + 5'd1;
        end else if (arq_q) begin
          tmo_d   = TW'(1);
          state_d = S_WAIT;
        end else begin
          done_d  = 1'b1;
          seq_d   = ~seq_q;
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (i_otn_tx_ack) begin
          done_d  = 1'b1;
          seq_d   = ~seq_q;
          state_d = S_IDLE;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
          if (retry_q < 4'(MAX_RETRIES)) begin
            retry_d   = retry_q + 4'd1;
            line_d    = 1'b1;
            bit_cnt_d = 5'd1;
            state_d   = S_SEND;
          end else begin
            drop_d  = 1'b1;
            seq_d   = ~seq_q;
            state_d = S_IDLE;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 5'd0;
      tmo_q     <= '0;
      retry_q   <= 4'd0;
      seq_q     <= 1'b0;
      arq_q     <= 1'b0;
      corrupt_q <= 1'b0;
      line_q    <= 1'b0;
      crc_q     <= 8'h00;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tmo_q     <= tmo_d;
      retry_q   <= retry_d;
      seq_q     <= seq_d;
      arq_q     <= arq_d;
      corrupt_q <= corrupt_d;
      line_q    <= line_d;
      crc_q     <= crc_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

  always_ff @(posedge i_clk) begin
    frame_q <= frame_d;
  end

  assign o_ready       = ready_q;
  assign o_otn_rx_data = line_q;
  assign o_crc_val     = crc_q;
  assign o_retry_cnt   = retry_q;
  assign o_tx_done     = done_q;
  assign o_drop        = drop_q;

endmodule

// File: tb/tb_arq_frame_tx.sv
// Directed bench for arq_frame_tx with hand-computed frames (TIMEOUT 64, 7 retries).
module tb_arq_frame_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       arq_en = 1'b0;
  logic       corrupt_en = 1'b0;
  logic       ack = 1'b0;
  logic       o_ready, o_otn_rx_data, o_tx_done, o_drop;
  logic [7:0] o_crc_val;
  logic [3:0] o_retry_cnt;

  int vectors = 0;
  int miscompares = 0;

  arq_frame_tx #(.TIMEOUT_CYCLES(64), .MAX_RETRIES(7)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid), .o_ready(o_ready),
    .i_arq_en(arq_en), .i_corrupt_en(corrupt_en), .o_otn_rx_data(o_otn_rx_data),
    .i_otn_tx_ack(ack), .o_crc_val(o_crc_val), .o_retry_cnt(o_retry_cnt),
    .o_tx_done(o_tx_done), .o_drop(o_drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a byte for one cycle T; returns positioned in cycle T+1.
  task automatic send_byte(input logic [7:0] d, input logic a, input logic c);
    vectors++;
    if (o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL send_ready: o_ready=%b required 1", o_ready);
    end
    data = d; arq_en = a; corrupt_en = c; valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    vectors++;
    if ({o_ready, o_otn_rx_data, o_crc_val, o_retry_cnt, o_tx_done, o_drop} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_vals: rdy=%b line=%b crc=%h retry=%0d done=%b drop=%b required all 0",
               o_ready, o_otn_rx_data, o_crc_val, o_retry_cnt, o_tx_done, o_drop);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: o_ready=%b required 1", o_ready);
    end
  endtask

  task automatic test_arq_off();
    logic [17:0] fr = {1'b1, 1'b0, 8'h01, 8'h07};
    send_byte(8'h01, 1'b0, 1'b0);
    vectors++;
    if (o_crc_val !== 8'h07 || o_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL off_crc: crc=%h rdy=%b required 07/0", o_crc_val, o_ready);
    end
    for (int i = 0; i < 18; i++) begin
      vectors++;
      if (o_otn_rx_data !== fr[17-i]) begin
        miscompares++;
        $display("FAIL off_bit%0d: line=%b required %b", i, o_otn_rx_data, fr[17-i]);
      end
      tick();
    end
    vectors++;
    if (o_tx_done !== 1'b1 || o_ready !== 1'b1 || o_otn_rx_data !== 1'b0) begin
      miscompares++;
      $display("FAIL off_done: done=%b rdy=%b line=%b required 1/1/0", o_tx_done, o_ready, o_otn_rx_data);
    end
    tick();
    vectors++;
    if (o_tx_done !== 1'b0) begin
      miscompares++;
      $display("FAIL off_pulse: done=%b required 0", o_tx_done);
    end
  endtask

  task automatic test_arq_ack();
    logic [17:0] fr = {1'b1, 1'b1, 8'h02, 8'h0E};
    int bad = 0;
    send_byte(8'h02, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) begin
      vectors++;
      if (o_otn_rx_data !== fr[17-i]) begin
        miscompares++;
        $display("FAIL ack_bit%0d: line=%b required %b", i, o_otn_rx_data, fr[17-i]);
      end
      tick();
    end
    vectors++;
    if (o_tx_done !== 1'b0 || o_ready !== 1'b0 || o_crc_val !== 8'h0E) begin
      miscompares++;
      $display("FAIL ack_wait: done=%b rdy=%b crc=%h required 0/0/0e", o_tx_done, o_ready, o_crc_val);
    end
    repeat (6) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    vectors++;
    if (o_tx_done !== 1'b1 || o_ready !== 1'b1 || o_retry_cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL ack_done: done=%b rdy=%b retry=%0d required 1/1/0", o_tx_done, o_ready, o_retry_cnt);
    end
    tick();
    for (int i = 0; i < 80; i++) begin
      if (o_otn_rx_data !== 1'b0 || o_ready !== 1'b1) bad++;
      tick();
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL ack_no_retx: %0d bad cycles required 0", bad);
    end
  endtask

  task automatic test_corrupt();
    logic [17:0] fr1 = {1'b1, 1'b0, 8'h03, 8'h0E};
    logic [17:0] fr2 = {1'b1, 1'b0, 8'h02, 8'h0E};
    int bad = 0;
    send_byte(8'h02, 1'b1, 1'b1);
    corrupt_en = 1'b0;
    for (int i = 0; i < 18; i++) begin
      vectors++;
      if (o_otn_rx_data !== fr1[17-i]) begin
        miscompares++;
        $display("FAIL cor1_bit%0d: line=%b required %b", i, o_otn_rx_data, fr1[17-i]);
      end
      tick();
    end
    for (int i = 0; i < 64; i++) begin
      if (o_otn_rx_data !== 1'b0) bad++;
      tick();
    end
    vectors++;
    if (bad !== 0 || o_retry_cnt !== 4'd1) begin
      miscompares++;
      $display("FAIL cor_gap: bad=%0d retry=%0d required 0/1", bad, o_retry_cnt);
    end
    for (int i = 0; i < 18; i++) begin
      vectors++;
      if (o_otn_rx_data !== fr2[17-i]) begin
        miscompares++;
        $display("FAIL cor2_bit%0d: line=%b required %b", i, o_otn_rx_data, fr2[17-i]);
      end
      tick();
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    vectors++;
    if (o_tx_done !== 1'b1 || o_retry_cnt !== 4'd1) begin
      miscompares++;
      $display("FAIL cor_done: done=%b retry=%0d required 1/1", o_tx_done, o_retry_cnt);
    end
    tick();
  endtask

  task automatic test_drop();
    logic [17:0] fr = {1'b1, 1'b1, 8'h80, 8'h89};
    int bad = 0;
    int p;
    logic expb;
    send_byte(8'h80, 1'b1, 1'b0);
    vectors++;
    if (o_crc_val !== 8'h89) begin
      miscompares++;
      $display("FAIL drop_crc: crc=%h required 89", o_crc_val);
    end
    for (int c = 1; c <= 656; c++) begin
      p = (c - 1) % 82;
      expb = (p < 18) ? fr[17-p] : 1'b0;
      if (o_otn_rx_data !== expb || o_drop !== 1'b0 || o_tx_done !== 1'b0 ||
          o_retry_cnt !== 4'((c - 1) / 82)) bad++;
      tick();
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL drop_seq: %0d bad cycles required 0", bad);
    end
    vectors++;
    if (o_drop !== 1'b1 || o_ready !== 1'b1 || o_retry_cnt !== 4'd7 || o_tx_done !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_pulse: drop=%b rdy=%b retry=%0d done=%b required 1/1/7/0",
               o_drop, o_ready, o_retry_cnt, o_tx_done);
    end
    tick();
    vectors++;
    if (o_drop !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_width: drop=%b required 0", o_drop);
    end
  endtask

  task automatic test_ack_in_send();
    logic [17:0] fr = {1'b1, 1'b0, 8'h01, 8'h07};
    int bad = 0;
    send_byte(8'h01, 1'b1, 1'b0);
    ack = 1'b1;
    for (int i = 0; i < 18; i++) begin
      vectors++;
      if (o_otn_rx_data !== fr[17-i]) begin
        miscompares++;
        $display("FAIL ais_bit%0d: line=%b required %b", i, o_otn_rx_data, fr[17-i]);
      end
      if (i == 17) ack = 1'b0;
      tick();
    end
    for (int i = 0; i < 64; i++) begin
      if (o_otn_rx_data !== 1'b0 || o_tx_done !== 1'b0) bad++;
      tick();
    end
    vectors++;
    if (bad !== 0 || o_otn_rx_data !== 1'b1 || o_retry_cnt !== 4'd1) begin
      miscompares++;
      $display("FAIL ais_retx: bad=%0d line=%b retry=%0d required 0/1/1", bad, o_otn_rx_data, o_retry_cnt);
    end
    repeat (18) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    vectors++;
    if (o_tx_done !== 1'b1) begin
      miscompares++;
      $display("FAIL ais_done: done=%b required 1", o_tx_done);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [17:0] fr = {1'b1, 1'b0, 8'h01, 8'h07};
    send_byte(8'h80, 1'b0, 1'b0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (o_otn_rx_data !== 1'b0 || o_ready !== 1'b0 || o_crc_val !== 8'h00) begin
      miscompares++;
      $display("FAIL rmid_clear: line=%b rdy=%b crc=%h required 0/0/00", o_otn_rx_data, o_ready, o_crc_val);
    end
    tick();
    send_byte(8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) begin
      vectors++;
      if (o_otn_rx_data !== fr[17-i]) begin
        miscompares++;
        $display("FAIL rmid_bit%0d: line=%b required %b", i, o_otn_rx_data, fr[17-i]);
      end
      tick();
    end
    vectors++;
    if (o_tx_done !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_done: done=%b required 1", o_tx_done);
    end
  endtask

  // Entered at the done cycle of the previous ARQ-off frame: 19-cycle period.
  task automatic test_back_to_back();
    logic [17:0] fr = {1'b1, 1'b1, 8'h02, 8'h0E};
    send_byte(8'h02, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) begin
      vectors++;
      if (o_otn_rx_data !== fr[17-i]) begin
        miscompares++;
        $display("FAIL b2b_bit%0d: line=%b required %b", i, o_otn_rx_data, fr[17-i]);
      end
      tick();
    end
    vectors++;
    if (o_tx_done !== 1'b1 || o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_done: done=%b rdy=%b required 1/1", o_tx_done, o_ready);
    end
  endtask

  initial begin
    test_reset();
    test_arq_off();
    test_arq_ack();
    test_corrupt();
    test_drop();
    test_ack_in_send();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
